display_scan_mux: RTL and testbench
===================================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLINK_DIV, default 64, scan frames per blink half-period; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 page_date  input  1  0 = time page, 1 = date page.
REQ-006 led_unit_sec, led_ten_sec, led_unit_min, led_ten_min, led_unit_hour, led_ten_hour, led_am_pm  input  7 each  time-page segment codes.
REQ-007 units_day_o, tens_day_o, units_month_o, tens_month_o, units_year_o, tens_year_o, hund_year_o, thou_year_o  input  7 each  date-page segment codes.
REQ-008 blink_mask  input  8  per-slot blink enable; bit n = slot n.
REQ-009 seg  output  7  multiplexed segment code, active-low (1 = segment off).
REQ-010 dig_en  output  8  digit enables, active-high, one-hot or all-zero.
REQ-011 frame_tick  output  1  one-cycle pulse at the end of slot 7.

Function
REQ-012 Slot counter: 3-bit, counts 0..7, wraps to 0; advances once every SCAN_DIV cycles.
REQ-013 Slot sequence, time page: 0 unit_sec, 1 ten_sec, 2 unit_min, 3 ten_min, 4 unit_hour, 5 ten_hour, 6 am_pm, 7 SEG_BLANK.
REQ-014 Slot sequence, date page: 0 units_day, 1 tens_day, 2 units_month, 3 tens_month, 4 units_year, 5 tens_year, 6 hund_year, 7 thou_year.
REQ-015 Guard cycle: the first cycle of every slot is a guard cycle, with dig_en = 0.
REQ-016 Active cycles: the remaining SCAN_DIV-1 cycles of each slot drive dig_en = 1<<slot.
REQ-017 seg is registered on the guard-cycle edge from the input sampled in the last cycle of the previous slot; it holds constant for the whole slot, so input changes inside a slot do not appear.
REQ-018 page_date is sampled only on the edge that wraps the slot counter 7->0; the latched page applies to the whole frame, so there is no mixed-page frame.
REQ-019 frame_tick is high in the last cycle of slot 7, the same cycle in which page_date is sampled.
REQ-020 blink_phase toggles after every BLINK_DIV frame_ticks; its value after reset is 1 (visible).
REQ-021 When blink_phase = 0 and blink_mask[slot] = 1, seg = SEG_BLANK for that slot; dig_en timing is unchanged.
REQ-022 blink_mask is sampled together with the segment input for each slot (REQ-017).

Reset
REQ-023 While rst = 0: seg = SEG_BLANK, dig_en = 0, frame_tick = 0, slot = 0, cycle counter = 0, page = time, blink_phase = 1, frame counter = 0.
REQ-024 Reset asserted mid-slot or mid-frame clears all state immediately, with no completion of the slot in progress.
REQ-025 After release, the first clock edge is a guard cycle of slot 0 on the time page.

Configuration
REQ-026 Macro DISP_BLINK_EN: when defined, blink_phase, the frame counter and REQ-020/021 are implemented.
REQ-027 When DISP_BLINK_EN is undefined: blink_mask is ignored, no blink logic is generated, and outputs are identical to the blink_phase = 1 case.

Structure
REQ-028 Package disp_pkg SHALL hold SEG_BLANK (7'b1111111), NUM_SLOTS (8), the page type (PAGE_TIME, PAGE_DATE) and the slot index type.
REQ-029 Sub-module scan_tick_gen SHALL provide the SCAN_DIV cycle divider and emit slot_start and slot_last strobes; display_scan_mux contains the slot/page/blink logic.

Verification (SCAN_DIV=4, BLINK_DIV=2, DISP_BLINK_EN defined unless noted)
REQ-030 Reset then release, time inputs 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h08 -> dig_en sequence per slot is 0,n,n,n; seg per slot matches REQ-013; slot 7 seg = 7'h7F; frame_tick every 32 cycles.
REQ-031 page_date raised in the middle of slot 3 -> slots 4..7 remain time page; from the next slot 0, seg = units_day_o.
REQ-032 led_unit_sec changed during its active cycles -> seg unchanged until slot 0 of the next frame.
REQ-033 blink_mask = 8'h30 -> slots 4 and 5 blank for frames 3-4 after reset, visible in frames 1-2 and 5-6; other slots always visible.
REQ-034 rst driven low in cycle 2 of slot 5 -> same cycle: seg = 7'h7F, dig_en = 0; after release, slot 0 restarts with a guard cycle.
REQ-035 Build without DISP_BLINK_EN, blink_mask = 8'hFF -> no blanking in any frame over 10 frames.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the display scan multiplexer.
// Segment codes are active-low: SEG_BLANK turns every segment off.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int NUM_SLOTS = 8;

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_t;

  typedef logic [2:0] slot_t;

  function automatic logic [7:0] slot_onehot(input slot_t s);
    return 8'b1 << s;
  endfunction

endpackage

// File: rtl/display_scan_mux_tick_gen.sv
// Slot-rate divider for the display scanner (module scan_tick_gen).
// Strobes describe the cycle whose closing edge starts/ends a slot.
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_start,
  output logic slot_last
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-SCAN_DIV cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Edge after a start strobe opens a slot (guard cycle);
  // edge after a last strobe begins the slot's final cycle.
  assign slot_start = (cnt == '0);
  assign slot_last  = (cnt == LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Eight-slot multiplexed 7-segment scanner with time/date pages.
// Optional blinking is built when DISP_BLINK_EN is defined.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       page_date,
  input  logic [6:0] led_unit_sec,
  input  logic [6:0] led_ten_sec,
  input  logic [6:0] led_unit_min,
  input  logic [6:0] led_ten_min,
  input  logic [6:0] led_unit_hour,
  input  logic [6:0] led_ten_hour,
  input  logic [6:0] led_am_pm,
  input  logic [6:0] units_day_o,
  input  logic [6:0] tens_day_o,
  input  logic [6:0] units_month_o,
  input  logic [6:0] tens_month_o,
  input  logic [6:0] units_year_o,
  input  logic [6:0] tens_year_o,
  input  logic [6:0] hund_year_o,
  input  logic [6:0] thou_year_o,
  input  logic [7:0] blink_mask,
  output logic [6:0] seg,
  output logic [7:0] dig_en,
  output logic       frame_tick
);

  slot_t      slot;
  page_t      page;
  page_t      page_nxt;
  logic       slot_start;
  logic       slot_last;
  logic       blank;
  logic [6:0] seg_sel;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .slot_start(slot_start),
    .slot_last (slot_last)
  );

  // frame_tick marks the cycle before slot 0's guard edge,
  // so the page is latched there and owns the whole frame.
  assign page_nxt = frame_tick ? page_t'(page_date) : page;

  // Source select for the slot about to be displayed.
  always_comb begin
    seg_sel = SEG_BLANK;
    if (page_nxt == PAGE_DATE) begin
      unique case (slot)
        3'd0: seg_sel = units_day_o;
        3'd1: seg_sel = tens_day_o;
        3'd2: seg_sel = units_month_o;
        3'd3: seg_sel = tens_month_o;
        3'd4: seg_sel = units_year_o;
        3'd5: seg_sel = tens_year_o;
        3'd6: seg_sel = hund_year_o;
        3'd7: seg_sel = thou_year_o;
      endcase
    end else begin
      unique case (slot)
        3'd0: seg_sel = led_unit_sec;
        3'd1: seg_sel = led_ten_sec;
        3'd2: seg_sel = led_unit_min;
        3'd3: seg_sel = led_ten_min;
        3'd4: seg_sel = led_unit_hour;
        3'd5: seg_sel = led_ten_hour;
        3'd6: seg_sel = led_am_pm;
        3'd7: seg_sel = SEG_BLANK;
      endcase
    end
  end

`ifdef DISP_BLINK_EN
  localparam logic [7:0] FLAST = 8'(BLINK_DIV - 1);

  logic [7:0] frame_cnt;
  logic       blink_phase;
  logic       phase_nxt;

  // Phase seen by the slot-0 guard edge already reflects
  // the toggle, so whole frames blink together.
  always_comb begin
    phase_nxt = blink_phase;
    if (frame_tick && frame_cnt == FLAST) begin
      phase_nxt = ~blink_phase;
    end
  end

  // Frame counter and blink phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_phase <= phase_nxt;
      if (frame_tick) begin
        frame_cnt <= (frame_cnt == FLAST) ? 8'd0 : frame_cnt + 8'd1;
      end
    end
  end

  assign blank = ~phase_nxt & blink_mask[slot];
`else
  logic unused_mask;

  assign unused_mask = ^blink_mask;
  assign blank       = 1'b0;
`endif

  // Slot sequencing and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot       <= '0;
      page       <= PAGE_TIME;
      seg        <= SEG_BLANK;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      page       <= page_nxt;
      frame_tick <= slot_last && (slot == 3'd7);
      if (slot_last) begin
        slot <= slot + 3'd1;
      end
      if (slot_start) begin
        seg    <= blank ? SEG_BLANK : seg_sel;
        dig_en <= '0;
      end else begin
        dig_en <= slot_onehot(slot);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized self-checking bench for display_scan_mux.
// Model derives slot/frame from the cycle index since release.
module tb_display_scan_mux;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FR = 8 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       page_date = 1'b0;
  logic [6:0] tin[7];
  logic [6:0] din[8];
  logic [7:0] blink_mask = 8'h00;
  logic [6:0] seg;
  logic [7:0] dig_en;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  logic       exp_page;
  logic [6:0] exp_seg;
  logic [6:0] sn_t[7];
  logic [6:0] sn_d[8];
  logic       sn_page;
  logic [7:0] sn_mask;

  display_scan_mux #(
    .SCAN_DIV (SD),
    .BLINK_DIV(BD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .page_date    (page_date),
    .led_unit_sec (tin[0]),
    .led_ten_sec  (tin[1]),
    .led_unit_min (tin[2]),
    .led_ten_min  (tin[3]),
    .led_unit_hour(tin[4]),
    .led_ten_hour (tin[5]),
    .led_am_pm    (tin[6]),
    .units_day_o  (din[0]),
    .tens_day_o   (din[1]),
    .units_month_o(din[2]),
    .tens_month_o (din[3]),
    .units_year_o (din[4]),
    .tens_year_o  (din[5]),
    .hund_year_o  (din[6]),
    .thou_year_o  (din[7]),
    .blink_mask   (blink_mask),
    .seg          (seg),
    .dig_en       (dig_en),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (k=%0d)", tag, got, want, k);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 7; i++) sn_t[i] = tin[i];
    for (int i = 0; i < 8; i++) sn_d[i] = din[i];
    sn_page = page_date;
    sn_mask = blink_mask;
  endtask

  // One clock: check the displayed cycle k against the model.
  task automatic cycle();
    int  slot;
    int  pos;
    int  f;
    logic vis;
    @(posedge clk);
    #1;
    slot = (k / SD) % 8;
    pos  = k % SD;
    f    = k / FR;
    if (pos == 0) begin
      if (slot == 0 && k > 0) exp_page = sn_page;
      if (exp_page) exp_seg = sn_d[slot];
      else exp_seg = (slot == 7) ? 7'h7F : sn_t[slot];
      vis = ((f / BD) % 2) == 0;
`ifdef DISP_BLINK_EN
      if (!vis && sn_mask[slot]) exp_seg = 7'h7F;
`else
      if (!vis) vis = 1'b1;
`endif
    end
    check("seg", 16'(seg), 16'(exp_seg));
    check("dig_en", 16'(dig_en),
          (pos == 0) ? 16'h0 : 16'(16'h1 << slot));
    check("frame_tick", 16'(frame_tick),
          16'(slot == 7 && pos == SD - 1));
    k++;
  endtask

  task automatic rand_inputs(input int chance);
    for (int i = 0; i < 7; i++)
      if ($urandom_range(0, chance - 1) == 0) tin[i] = 7'($urandom);
    for (int i = 0; i < 8; i++)
      if ($urandom_range(0, chance - 1) == 0) din[i] = 7'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dig"}, 16'(dig_en), 16'h0);
    check({tag, "_ft"}, 16'(frame_tick), 16'h0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    exp_page = 1'b0;
    exp_seg = 7'h7F;
    snap();
  endtask

  initial begin
    tin[0] = 7'h40; tin[1] = 7'h79; tin[2] = 7'h24;
    tin[3] = 7'h30; tin[4] = 7'h19; tin[5] = 7'h12;
    tin[6] = 7'h08;
    for (int i = 0; i < 8; i++) din[i] = 7'($urandom);
    blink_mask = 8'h30;
    exp_page = 1'b0;
    exp_seg = 7'h7F;
    snap();

    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("por");
    end
    release_rst();

    // Fixed time page, blink on slots 4/5, unit_sec moved mid-slot.
    repeat (6 * FR) begin
      cycle();
      if ((k - 1) % FR == 2) tin[0] = 7'($urandom);
      snap();
    end

    // Page switch in the middle of slot 3.
    blink_mask = 8'h00;
    repeat (2 * FR) begin
      cycle();
      if ((k - 1) % FR == 13) page_date = 1'b1;
      snap();
    end

    // Random traffic.
    repeat (12 * FR) begin
      cycle();
      rand_inputs(8);
      if ($urandom_range(0, 63) == 0) page_date = ~page_date;
      if ((k - 1) % FR == FR - 1) blink_mask = 8'($urandom);
      snap();
    end

    // Reset in cycle 2 of slot 5.
    for (int n = 0; n < FR; n++) begin
      cycle();
      snap();
      if ((k - 1) % FR == 5 * SD + 2) break;
    end
    check("reset_pos", 16'((k - 1) % FR), 16'(5 * SD + 2));
    rst = 1'b0;
    #1;
    check_reset("mid");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset("hold");
    end
    release_rst();

    repeat (4 * FR) begin
      cycle();
      rand_inputs(6);
      if ($urandom_range(0, 31) == 0) page_date = ~page_date;
      if ((k - 1) % FR == FR - 1) blink_mask = 8'($urandom);
      snap();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
